// File: rtl/read_module.sv
// Sequential memory reader: issues one address per cycle from a latched base and
// captures the returned words into a scalar or a packed LANES-wide vector result.
module read_module #(
  parameter int unsigned LANES  = 20,
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_op_type,
  input  logic [ADDR_W-1:0]        i_base_address,
  output logic [ADDR_W-1:0]        o_read_address,
  output logic                     o_read_en,
  input  logic [WIDTH-1:0]         i_read_data,
  output logic [WIDTH-1:0]         o_scalar_data,
  output logic [LANES*WIDTH-1:0]   o_vector_data,
  output logic                     o_busy,
  output logic                     o_finished
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state,        w_state;
  logic                     r_op,           w_op;
  logic [ADDR_W-1:0]        r_base,         w_base;
  logic [IDX_W-1:0]         r_idx,          w_idx;
  logic                     r_p1_v,         w_p1_v;
  logic [IDX_W-1:0]         r_p1_idx,       w_p1_idx;
  logic [ADDR_W-1:0]        r_read_address, w_read_address;
  logic                     r_read_en,      w_read_en;
  logic [WIDTH-1:0]         r_scalar_data,  w_scalar_data;
  logic [LANES*WIDTH-1:0]   r_vector_data,  w_vector_data;
  logic                     r_busy,         w_busy;
  logic                     r_finished,     w_finished;
  logic [IDX_W-1:0]         w_idx_inc;
  logic                     w_last;

  assign o_read_address = r_read_address;
  assign o_read_en      = r_read_en;
  assign o_scalar_data  = r_scalar_data;
  assign o_vector_data  = r_vector_data;
  assign o_busy         = r_busy;
  assign o_finished     = r_finished;

  assign w_idx_inc = IDX_W'(r_idx + IDX_W'(1));
  assign w_last    = r_op ? (r_idx == IDX_W'(LANES - 1)) : 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_op           <= 1'b0;
      r_base         <= '0;
      r_idx          <= '0;
      r_p1_v         <= 1'b0;
      r_p1_idx       <= '0;
      r_read_address <= '0;
      r_read_en      <= 1'b0;
      r_scalar_data  <= '0;
      r_vector_data  <= '0;
      r_busy         <= 1'b0;
      r_finished     <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_op           <= w_op;
      r_base         <= w_base;
      r_idx          <= w_idx;
      r_p1_v         <= w_p1_v;
      r_p1_idx       <= w_p1_idx;
      r_read_address <= w_read_address;
      r_read_en      <= w_read_en;
      r_scalar_data  <= w_scalar_data;
      r_vector_data  <= w_vector_data;
      r_busy         <= w_busy;
      r_finished     <= w_finished;
    end
  end

  always_comb begin
    w_state        = r_state;
    w_op           = r_op;
    w_base         = r_base;
    w_idx          = r_idx;
    w_read_address = r_read_address;
    w_read_en      = r_read_en;
    w_scalar_data  = r_scalar_data;
    w_vector_data  = r_vector_data;
    w_busy         = r_busy;
    w_finished     = 1'b0;
    // Memory returns data one cycle after the address is registered, so the
    // issue slot (en, idx) is delayed one stage to line up with i_read_data.
    w_p1_v         = r_read_en;
    w_p1_idx       = r_idx;

    if (r_p1_v) begin
      if (r_op) begin
        for (int k = 0; k < int'(LANES); k++) begin
          if (r_p1_idx == IDX_W'(k)) w_vector_data[k*WIDTH +: WIDTH] = i_read_data;
        end
      end else begin
        w_scalar_data = i_read_data;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_op           = i_op_type;
          w_base         = i_base_address;
          w_idx          = '0;
          w_read_address = i_base_address;
          w_read_en      = 1'b1;
          w_busy         = 1'b1;
          w_state        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_last) begin
          w_read_en = 1'b0;
          w_state   = S_DRAIN;
        end else begin
          w_idx          = w_idx_inc;
          w_read_address = ADDR_W'(r_base + ADDR_W'(w_idx_inc));
        end
      end
      S_DRAIN: begin
        w_finished = 1'b1;
        w_busy     = 1'b0;
        w_state    = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

endmodule
